issue_queue_dual: RTL and testbench

- Parametrised successor to the combinational dual-launch selector.
- Decoded instruction pairs are buffered in a DEPTH-entry in-order queue.
- Operands are resolved against NFWD forwarding channels and the register file.
- Up to two instructions issue per cycle into registered ALU/branch (pipe 0) and AG (pipe 1) output stages with valid/ready handshakes; a flush empties everything.

---
 rtl/issue_queue_dual_if.sv | 68 ++++++
 rtl/issue_queue_dual.sv | 251 +++++++++++++++++++++++++
 tb/tb_issue_queue_dual.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_queue_dual_if.sv
// issue_queue_dual_if
//   Bundles every handshake/bus signal of issue_queue_dual.
//   slave  : the issue queue itself.
//   master : the surrounding pipeline (decode, forwarding network, RF, EX).
//
//   Signal groups:
//     in_*     decoded instruction pair, in_valid[1] implies in_valid[0]
//     fwd_*    NFWD forwarding channels, channel 0 youngest / highest priority
//     rf_*     four combinational register-file read ports
//     ex0_*    pipe 0 (ALU/branch) output stage
//     ex1_*    pipe 1 (AG) output stage
//     ex_older pipe index holding the older instruction of a dual issue
//     *_cnt    performance counters
//
//   Valid/ready semantics (all handshakes): a transfer happens on a rising
//   clock edge where valid and ready are both 1. While valid is 1 and ready
//   is 0, the producer holds valid and the whole payload stable. The input
//   side accepts the pair as a unit: in_ready only says two entries are free.
interface issue_queue_dual_if #(
  parameter int NFWD = 4,
  parameter int DW   = 32,
  parameter int PCW  = 32,
  parameter int DCW  = 64
);
  logic [1:0]        in_valid;
  logic              in_ready;
  logic [PCW-1:0]    in0_pc, in1_pc, in0_npc, in1_npc;
  logic [DCW-1:0]    in0_dec, in1_dec;

  logic [NFWD-1:0]   fwd_we;
  logic [NFWD-1:0]   fwd_done;
  logic [NFWD*5-1:0] fwd_addr;
  logic [NFWD*DW-1:0] fwd_data;

  logic [4*5-1:0]    rf_raddr;
  logic [4*DW-1:0]   rf_rdata;

  logic              ex0_valid, ex0_ready;
  logic [PCW-1:0]    ex0_pc, ex0_npc;
  logic [DCW-1:0]    ex0_dec;
  logic [DW-1:0]     ex0_opa, ex0_opb;

  logic              ex1_valid, ex1_ready;
  logic [PCW-1:0]    ex1_pc, ex1_npc;
  logic [DCW-1:0]    ex1_dec;
  logic [DW-1:0]     ex1_opa, ex1_opb;

  logic              ex_older;
  logic [31:0]       stall_cnt, dual_cnt;

  modport slave (
    input  in_valid, in0_pc, in1_pc, in0_npc, in1_npc, in0_dec, in1_dec,
    input  fwd_we, fwd_done, fwd_addr, fwd_data, rf_rdata, ex0_ready, ex1_ready,
    output in_ready, rf_raddr,
    output ex0_valid, ex0_pc, ex0_npc, ex0_dec, ex0_opa, ex0_opb,
    output ex1_valid, ex1_pc, ex1_npc, ex1_dec, ex1_opa, ex1_opb,
    output ex_older, stall_cnt, dual_cnt
  );

  modport master (
    output in_valid, in0_pc, in1_pc, in0_npc, in1_npc, in0_dec, in1_dec,
    output fwd_we, fwd_done, fwd_addr, fwd_data, rf_rdata, ex0_ready, ex1_ready,
    input  in_ready, rf_raddr,
    input  ex0_valid, ex0_pc, ex0_npc, ex0_dec, ex0_opa, ex0_opb,
    input  ex1_valid, ex1_pc, ex1_npc, ex1_dec, ex1_opa, ex1_opb,
    input  ex_older, stall_cnt, dual_cnt
  );
endinterface

// File: rtl/issue_queue_dual.sv
// issue_queue_dual
//   DEPTH-entry in-order issue queue feeding two registered output stages:
//   pipe 0 (ALU/branch) and pipe 1 (AG). Operands of the two oldest entries
//   are resolved against NFWD forwarding channels and the register file;
//   up to two instructions issue per cycle, strictly in program order.
//
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset
//     flush  synchronous clear of queue and output stages
//     bus    issue_queue_dual_if.slave (input pair, forwarding, RF, EX stages)
//
//   Optional feature: define ISSUE_PERF_CNT_EN to build the stall/dual
//   performance counters; otherwise stall_cnt and dual_cnt read 0.
//
//   Decode bus fields used here:
//     [3:0] insttype  [8:4] rs  [13:9] rt  [14] rs valid  [15] rt valid
//     [16] write enable  [21:17] write address
module issue_queue_dual #(
  parameter int DEPTH = 4,
  parameter int NFWD  = 4,
  parameter int DW    = 32,
  parameter int PCW   = 32,
  parameter int DCW   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  issue_queue_dual_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam int DC_INSTTYPE = 0;
  localparam int DC_RS       = 4;
  localparam int DC_RT       = 9;
  localparam int DC_RSV      = 14;
  localparam int DC_RTV      = 15;
  localparam int DC_WE       = 16;
  localparam int DC_WA       = 17;
  localparam logic [3:0] INSTTYPE_AG = 4'd2;

  // Storage
  logic [PCW-1:0] pc_mem  [DEPTH];
  logic [PCW-1:0] npc_mem [DEPTH];
  logic [DCW-1:0] dec_mem [DEPTH];

  logic [AW-1:0] head, tail, head1, tail1;
  logic [CW-1:0] count;

  logic           ex0_valid_q, ex1_valid_q, older_q;
  logic [PCW-1:0] ex0_pc_q, ex0_npc_q, ex1_pc_q, ex1_npc_q;
  logic [DCW-1:0] ex0_dec_q, ex1_dec_q;
  logic [DW-1:0]  ex0_opa_q, ex0_opb_q, ex1_opa_q, ex1_opb_q;

  // Returns {ready, value}. The first matching channel in ascending order
  // wins, so a younger producer shadows an older one for the same register.
  function automatic logic [DW:0] resolve(
    input logic              v,
    input logic [4:0]        a,
    input logic [DW-1:0]     rf,
    input logic [NFWD-1:0]   we,
    input logic [NFWD-1:0]   done,
    input logic [NFWD*5-1:0] addr,
    input logic [NFWD*DW-1:0] data
  );
    logic [DW:0] res;
    logic        hit;
    res = {1'b1, rf};
    hit = 1'b0;
    if (!v || a == 5'd0) begin
      res = {1'b1, {DW{1'b0}}};
    end else begin
      for (int i = 0; i < NFWD; i++) begin
        if (!hit && we[i] && addr[i*5 +: 5] == a) begin
          hit = 1'b1;
          res = {done[i], data[i*DW +: DW]};
        end
      end
    end
    return res;
  endfunction

  assign head1 = head + AW'(1);
  assign tail1 = tail + AW'(1);

  logic [DCW-1:0] d0, d1;
  assign d0 = dec_mem[head];
  assign d1 = dec_mem[head1];

  assign bus.rf_raddr = {d1[DC_RT +: 5], d1[DC_RS +: 5], d0[DC_RT +: 5], d0[DC_RS +: 5]};

  logic [DW:0] r_ha, r_hb, r_na, r_nb;
  assign r_ha = resolve(d0[DC_RSV], d0[DC_RS +: 5], bus.rf_rdata[0*DW +: DW],
                        bus.fwd_we, bus.fwd_done, bus.fwd_addr, bus.fwd_data);
  assign r_hb = resolve(d0[DC_RTV], d0[DC_RT +: 5], bus.rf_rdata[1*DW +: DW],
                        bus.fwd_we, bus.fwd_done, bus.fwd_addr, bus.fwd_data);
  assign r_na = resolve(d1[DC_RSV], d1[DC_RS +: 5], bus.rf_rdata[2*DW +: DW],
                        bus.fwd_we, bus.fwd_done, bus.fwd_addr, bus.fwd_data);
  assign r_nb = resolve(d1[DC_RTV], d1[DC_RT +: 5], bus.rf_rdata[3*DW +: DW],
                        bus.fwd_we, bus.fwd_done, bus.fwd_addr, bus.fwd_data);

  // Issue selection
  logic       h_ag, n_ag, dep, issue_h, issue_n;
  logic [1:0] pipe_free;
  logic       ld0, ld1, use_n0, use_n1;

  always_comb begin
    h_ag      = (d0[DC_INSTTYPE +: 4] == INSTTYPE_AG);
    n_ag      = (d1[DC_INSTTYPE +: 4] == INSTTYPE_AG);
    pipe_free = {!ex1_valid_q || bus.ex1_ready, !ex0_valid_q || bus.ex0_ready};
    // head+1 must not read what the head writes in the same cycle
    dep = d0[DC_WE] && (d0[DC_WA +: 5] != 5'd0) &&
          ((d1[DC_RSV] && d1[DC_RS +: 5] == d0[DC_WA +: 5]) ||
           (d1[DC_RTV] && d1[DC_RT +: 5] == d0[DC_WA +: 5]));
    issue_h = (count != '0) && r_ha[DW] && r_hb[DW] && pipe_free[h_ag];
    issue_n = issue_h && (count >= CW'(2)) && r_na[DW] && r_nb[DW] &&
              (n_ag != h_ag) && pipe_free[n_ag] && !dep;
    ld0    = (issue_h && !h_ag) || (issue_n && !n_ag);
    ld1    = (issue_h && h_ag)  || (issue_n && n_ag);
    // a pipe not fed by the head can only be fed by head+1
    use_n0 = !(issue_h && !h_ag);
    use_n1 = !(issue_h && h_ag);
  end

  // Enqueue/dequeue bookkeeping
  logic          in_ready_w, enq;
  logic [CW-1:0] n_enq, n_deq;

  assign in_ready_w = (count <= CW'(DEPTH - 2));
  assign bus.in_ready = in_ready_w;
  assign enq   = bus.in_valid[0] && in_ready_w;
  assign n_enq = !enq ? CW'(0) : (bus.in_valid[1] ? CW'(2) : CW'(1));
  assign n_deq = CW'(issue_h) + CW'(issue_n);

  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      pc_mem[tail]  <= bus.in0_pc;
      npc_mem[tail] <= bus.in0_npc;
      dec_mem[tail] <= bus.in0_dec;
      if (bus.in_valid[1]) begin
        pc_mem[tail1]  <= bus.in1_pc;
        npc_mem[tail1] <= bus.in1_npc;
        dec_mem[tail1] <= bus.in1_dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      ex0_valid_q <= 1'b0;
      ex1_valid_q <= 1'b0;
      older_q     <= 1'b0;
      ex0_pc_q    <= '0;
      ex0_npc_q   <= '0;
      ex0_dec_q   <= '0;
      ex0_opa_q   <= '0;
      ex0_opb_q   <= '0;
      ex1_pc_q    <= '0;
      ex1_npc_q   <= '0;
      ex1_dec_q   <= '0;
      ex1_opa_q   <= '0;
      ex1_opb_q   <= '0;
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      ex0_valid_q <= 1'b0;
      ex1_valid_q <= 1'b0;
      older_q     <= 1'b0;
    end else begin
      head  <= head + AW'(n_deq);
      tail  <= tail + AW'(n_enq);
      count <= count + n_enq - n_deq;

      if (ld0) begin
        ex0_valid_q <= 1'b1;
        ex0_pc_q    <= use_n0 ? pc_mem[head1]  : pc_mem[head];
        ex0_npc_q   <= use_n0 ? npc_mem[head1] : npc_mem[head];
        ex0_dec_q   <= use_n0 ? d1 : d0;
        ex0_opa_q   <= use_n0 ? r_na[DW-1:0] : r_ha[DW-1:0];
        ex0_opb_q   <= use_n0 ? r_nb[DW-1:0] : r_hb[DW-1:0];
      end else if (bus.ex0_ready) begin
        ex0_valid_q <= 1'b0;
        ex0_pc_q    <= '0;
        ex0_npc_q   <= '0;
        ex0_dec_q   <= '0;
        ex0_opa_q   <= '0;
        ex0_opb_q   <= '0;
      end

      if (ld1) begin
        ex1_valid_q <= 1'b1;
        ex1_pc_q    <= use_n1 ? pc_mem[head1]  : pc_mem[head];
        ex1_npc_q   <= use_n1 ? npc_mem[head1] : npc_mem[head];
        ex1_dec_q   <= use_n1 ? d1 : d0;
        ex1_opa_q   <= use_n1 ? r_na[DW-1:0] : r_ha[DW-1:0];
        ex1_opb_q   <= use_n1 ? r_nb[DW-1:0] : r_hb[DW-1:0];
      end else if (bus.ex1_ready) begin
        ex1_valid_q <= 1'b0;
        ex1_pc_q    <= '0;
        ex1_npc_q   <= '0;
        ex1_dec_q   <= '0;
        ex1_opa_q   <= '0;
        ex1_opb_q   <= '0;
      end

      if (issue_h) older_q <= issue_n ? h_ag : 1'b0;
    end
  end

  assign bus.ex0_valid = ex0_valid_q;
  assign bus.ex0_pc    = ex0_pc_q;
  assign bus.ex0_npc   = ex0_npc_q;
  assign bus.ex0_dec   = ex0_dec_q;
  assign bus.ex0_opa   = ex0_opa_q;
  assign bus.ex0_opb   = ex0_opb_q;
  assign bus.ex1_valid = ex1_valid_q;
  assign bus.ex1_pc    = ex1_pc_q;
  assign bus.ex1_npc   = ex1_npc_q;
  assign bus.ex1_dec   = ex1_dec_q;
  assign bus.ex1_opa   = ex1_opa_q;
  assign bus.ex1_opb   = ex1_opb_q;
  assign bus.ex_older  = older_q;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] stall_q, dual_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      dual_q  <= '0;
    end else if (!flush) begin
      if (count != '0 && !issue_h) stall_q <= stall_q + 32'd1;
      if (issue_n)                 dual_q  <= dual_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.dual_cnt  = dual_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.dual_cnt  = '0;
`endif

endmodule

// File: tb/tb_issue_queue_dual.sv
module tb_issue_queue_dual;
  localparam int DEPTH = 4;
  localparam int NFWD  = 4;
  localparam int DW    = 32;
  localparam int PCW   = 32;
  localparam int DCW   = 64;
  localparam int AG    = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  issue_queue_dual_if #(.NFWD(NFWD), .DW(DW), .PCW(PCW), .DCW(DCW)) bus ();

  issue_queue_dual #(.DEPTH(DEPTH), .NFWD(NFWD), .DW(DW), .PCW(PCW), .DCW(DCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  // register file model answering the DUT's read ports
  logic [DW-1:0] rf_mem [32];
  assign bus.rf_rdata = {rf_mem[bus.rf_raddr[19:15]], rf_mem[bus.rf_raddr[14:10]],
                         rf_mem[bus.rf_raddr[9:5]],   rf_mem[bus.rf_raddr[4:0]]};

  // reference model
  typedef struct {
    logic [PCW-1:0] pc;
    logic [PCW-1:0] npc;
    logic [DCW-1:0] dec;
  } ent_t;
  typedef struct {
    logic           valid;
    logic [PCW-1:0] pc;
    logic [PCW-1:0] npc;
    logic [DCW-1:0] dec;
    logic [DW-1:0]  opa;
    logic [DW-1:0]  opb;
  } ex_t;

  ent_t        exp_q[$];
  ex_t         mex[2];
  logic        m_older;
  logic [31:0] m_stall, m_dual;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DCW-1:0] mk(input int ty, input int rs, input bit rsv,
                                        input int rt, input bit rtv, input bit we, input int wa);
    logic [DCW-1:0] d;
    d = {$urandom(), $urandom()};
    d[3:0]   = 4'(ty);
    d[8:4]   = 5'(rs);
    d[13:9]  = 5'(rt);
    d[14]    = rsv;
    d[15]    = rtv;
    d[16]    = we;
    d[21:17] = 5'(wa);
    return d;
  endfunction

  // {ready, value} for one source under the operand rules
  function automatic logic [DW:0] m_res(input logic v, input logic [4:0] a);
    if (!v || a == 5'd0) return {1'b1, {DW{1'b0}}};
    for (int i = 0; i < NFWD; i++)
      if (bus.fwd_we[i] && bus.fwd_addr[i*5 +: 5] == a)
        return {bus.fwd_done[i], bus.fwd_data[i*DW +: DW]};
    return {1'b1, rf_mem[a]};
  endfunction

  function automatic bit is_ag(input logic [DCW-1:0] d);
    return d[3:0] == 4'(AG);
  endfunction

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_cycle();
    logic [DW:0] a0, b0, a1, b1;
    bit iss0, iss1, p0, p1, dep;
    bit free[2], rdy[2];
    int sz;
    ent_t e0, e1;
    sz = exp_q.size();
    if (flush) begin
      exp_q.delete();
      mex[0].valid = 1'b0;
      mex[1].valid = 1'b0;
      m_older = 1'b0;
      return;
    end
    rdy[0] = bus.ex0_ready;
    rdy[1] = bus.ex1_ready;
    for (int p = 0; p < 2; p++) free[p] = !mex[p].valid || rdy[p];
    iss0 = 0; iss1 = 0; p0 = 0; p1 = 0;
    if (sz >= 1) begin
      e0 = exp_q[0];
      a0 = m_res(e0.dec[14], e0.dec[8:4]);
      b0 = m_res(e0.dec[15], e0.dec[13:9]);
      p0 = is_ag(e0.dec);
      iss0 = a0[DW] && b0[DW] && free[p0];
    end
    if (iss0 && sz >= 2) begin
      e1 = exp_q[1];
      a1 = m_res(e1.dec[14], e1.dec[8:4]);
      b1 = m_res(e1.dec[15], e1.dec[13:9]);
      p1 = is_ag(e1.dec);
      dep = e0.dec[16] && e0.dec[21:17] != 5'd0 &&
            ((e1.dec[14] && e1.dec[8:4] == e0.dec[21:17]) ||
             (e1.dec[15] && e1.dec[13:9] == e0.dec[21:17]));
      iss1 = a1[DW] && b1[DW] && (p1 != p0) && free[p1] && !dep;
    end
    for (int p = 0; p < 2; p++) if (rdy[p]) mex[p] = '{default: '0};
    if (iss0) mex[p0] = '{valid: 1'b1, pc: e0.pc, npc: e0.npc, dec: e0.dec, opa: a0[DW-1:0], opb: b0[DW-1:0]};
    if (iss1) mex[p1] = '{valid: 1'b1, pc: e1.pc, npc: e1.npc, dec: e1.dec, opa: a1[DW-1:0], opb: b1[DW-1:0]};
    if (iss0) m_older = iss1 ? p0 : 1'b0;
    if (sz > 0 && !iss0) m_stall++;
    if (iss1) m_dual++;
    if (iss0) void'(exp_q.pop_front());
    if (iss1) void'(exp_q.pop_front());
    if (bus.in_valid[0] && (DEPTH - sz >= 2)) begin
      exp_q.push_back('{pc: bus.in0_pc, npc: bus.in0_npc, dec: bus.in0_dec});
      if (bus.in_valid[1]) exp_q.push_back('{pc: bus.in1_pc, npc: bus.in1_npc, dec: bus.in1_dec});
    end
  endtask

  task automatic compare_all();
    check("in_ready", bus.in_ready, 64'(DEPTH - exp_q.size() >= 2));
    check("ex0_valid", bus.ex0_valid, mex[0].valid);
    check("ex1_valid", bus.ex1_valid, mex[1].valid);
    check("ex_older", bus.ex_older, m_older);
    if (mex[0].valid) begin
      check("ex0_pc", bus.ex0_pc, mex[0].pc);
      check("ex0_npc", bus.ex0_npc, mex[0].npc);
      check("ex0_dec", bus.ex0_dec, mex[0].dec);
      check("ex0_opa", bus.ex0_opa, mex[0].opa);
      check("ex0_opb", bus.ex0_opb, mex[0].opb);
    end
    if (mex[1].valid) begin
      check("ex1_pc", bus.ex1_pc, mex[1].pc);
      check("ex1_npc", bus.ex1_npc, mex[1].npc);
      check("ex1_dec", bus.ex1_dec, mex[1].dec);
      check("ex1_opa", bus.ex1_opa, mex[1].opa);
      check("ex1_opb", bus.ex1_opb, mex[1].opb);
    end
    if (exp_q.size() >= 1) begin
      check("rf_raddr_h_rs", bus.rf_raddr[4:0], exp_q[0].dec[8:4]);
      check("rf_raddr_h_rt", bus.rf_raddr[9:5], exp_q[0].dec[13:9]);
    end
    if (exp_q.size() >= 2) begin
      check("rf_raddr_n_rs", bus.rf_raddr[14:10], exp_q[1].dec[8:4]);
      check("rf_raddr_n_rt", bus.rf_raddr[19:15], exp_q[1].dec[13:9]);
    end
`ifdef ISSUE_PERF_CNT_EN
    check("stall_cnt", bus.stall_cnt, m_stall);
    check("dual_cnt", bus.dual_cnt, m_dual);
`else
    check("stall_cnt", bus.stall_cnt, 64'd0);
    check("dual_cnt", bus.dual_cnt, 64'd0);
`endif
  endtask

  // driver tasks
  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    bus.in_valid  = 2'b00;
    bus.in0_pc = '0; bus.in0_npc = '0; bus.in0_dec = '0;
    bus.in1_pc = '0; bus.in1_npc = '0; bus.in1_dec = '0;
    bus.fwd_we    = '0;
    bus.fwd_done  = '1;
    bus.fwd_addr  = '0;
    bus.fwd_data  = '0;
    bus.ex0_ready = 1'b1;
    bus.ex1_ready = 1'b1;
    flush = 1'b0;
  endtask

  task automatic pair(input logic [1:0] v, input logic [PCW-1:0] pc0, input logic [DCW-1:0] dc0,
                      input logic [PCW-1:0] pc1, input logic [DCW-1:0] dc1);
    bus.in_valid = v;
    bus.in0_pc = pc0; bus.in0_npc = pc0 + 4; bus.in0_dec = dc0;
    bus.in1_pc = pc1; bus.in1_npc = pc1 + 4; bus.in1_dec = dc1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    mex[0] = '{default: '0};
    mex[1] = '{default: '0};
    m_older = 1'b0;
    m_stall = '0;
    m_dual  = '0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ex0_valid"}, bus.ex0_valid, 64'd0);
    check({tag, "_ex1_valid"}, bus.ex1_valid, 64'd0);
    check({tag, "_ex_older"}, bus.ex_older, 64'd0);
    check({tag, "_ex0_pc"}, bus.ex0_pc, 64'd0);
    check({tag, "_ex1_opa"}, bus.ex1_opa, 64'd0);
    check({tag, "_ex0_dec"}, bus.ex0_dec, 64'd0);
    check({tag, "_in_ready"}, bus.in_ready, 64'd1);
    check({tag, "_stall_cnt"}, bus.stall_cnt, 64'd0);
    check({tag, "_dual_cnt"}, bus.dual_cnt, 64'd0);
  endtask

  initial begin
    logic [31:0] s0, d0;
    int r;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom();
    idle();
    model_reset();
    rst_n = 1'b0;
    #1;
    reset_checks("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // independent ALU + AG pair dual-issues
    pair(2'b11, 32'h100, mk(0, 1, 1, 2, 1, 1, 3), 32'h104, mk(AG, 4, 1, 0, 0, 0, 0));
    step();
    bus.in_valid = 2'b00;
    step();
    check("t1_ex0_pc", bus.ex0_pc, 64'h100);
    check("t1_ex1_pc", bus.ex1_pc, 64'h104);
    check("t1_ex0_valid", bus.ex0_valid, 64'd1);
    check("t1_ex1_valid", bus.ex1_valid, 64'd1);
    check("t1_ex_older", bus.ex_older, 64'd0);
`ifdef ISSUE_PERF_CNT_EN
    check("t1_dual_cnt", bus.dual_cnt, 64'd1);
`endif
    step();

    // pending producer stalls the head until data is done
    idle();
    bus.fwd_we = 4'b0100;
    bus.fwd_addr[14:10] = 5'd5;
    bus.fwd_done = 4'b1011;
    pair(2'b01, 32'h200, mk(0, 5, 1, 0, 0, 0, 0), 32'h0, '0);
    step();
    bus.in_valid = 2'b00;
    s0 = m_stall;
    step();
    step();
    check("t2_stalled", bus.ex0_valid, 64'd0);
`ifdef ISSUE_PERF_CNT_EN
    check("t2_stall_cnt", bus.stall_cnt, 64'(s0 + 2));
`endif
    bus.fwd_done = 4'b1111;
    bus.fwd_data[95:64] = 32'hDEAD;
    step();
    check("t2_ex0_opa", bus.ex0_opa, 64'hDEAD);
    idle();
    step();

    // channel priority and register 0
    bus.fwd_we = 4'b1011;
    bus.fwd_addr[4:0] = 5'd7;   bus.fwd_data[31:0]   = 32'h11;
    bus.fwd_addr[9:5] = 5'd0;   bus.fwd_data[63:32]  = 32'h55;
    bus.fwd_addr[19:15] = 5'd7; bus.fwd_data[127:96] = 32'h22;
    pair(2'b01, 32'h280, mk(0, 7, 1, 0, 1, 0, 0), 32'h0, '0);
    step();
    bus.in_valid = 2'b00;
    step();
    check("t3_opa_ch0", bus.ex0_opa, 64'h11);
    check("t3_opb_r0", bus.ex0_opb, 64'h0);
    idle();
    step();

    // RAW inside the pair forces single issue
    pair(2'b11, 32'h300, mk(0, 1, 1, 0, 0, 1, 3), 32'h304, mk(AG, 3, 1, 0, 0, 0, 0));
    step();
    bus.in_valid = 2'b00;
    step();
    check("t4_ex0_pc", bus.ex0_pc, 64'h300);
    check("t4_ex1_held", bus.ex1_valid, 64'd0);
    step();
    check("t4_ex1_valid", bus.ex1_valid, 64'd1);
    check("t4_ex1_pc", bus.ex1_pc, 64'h304);
    // two ALU ops serialise on pipe 0
    pair(2'b11, 32'h310, mk(0, 1, 1, 2, 1, 0, 0), 32'h314, mk(1, 2, 1, 1, 1, 0, 0));
    step();
    bus.in_valid = 2'b00;
    step();
    check("t4_alu_a", bus.ex0_pc, 64'h310);
    check("t4_alu_a_only", bus.ex1_valid, 64'd0);
    step();
    check("t4_alu_b", bus.ex0_pc, 64'h314);
    step();

    // fill with pipe 0 blocked, then drain across the wrap
    bus.ex0_ready = 1'b0;
    pair(2'b11, 32'h400, mk(0, 0, 0, 0, 0, 0, 0), 32'h404, mk(0, 0, 0, 0, 0, 0, 0));
    step();
    pair(2'b11, 32'h408, mk(0, 0, 0, 0, 0, 0, 0), 32'h40c, mk(0, 0, 0, 0, 0, 0, 0));
    step();
    check("t5_full_ready", bus.in_ready, 64'd0);
    pair(2'b11, 32'h410, mk(0, 0, 0, 0, 0, 0, 0), 32'h414, mk(0, 0, 0, 0, 0, 0, 0));
    step();
    check("t5_still_blocked", bus.in_ready, 64'd0);
    check("t5_ex0_head", bus.ex0_pc, 64'h400);
    bus.in_valid = 2'b00;
    bus.ex0_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // flush with full queue and both stages occupied
    bus.ex0_ready = 1'b0;
    bus.ex1_ready = 1'b0;
    pair(2'b11, 32'h500, mk(0, 1, 1, 0, 0, 0, 0), 32'h504, mk(AG, 2, 1, 0, 0, 0, 0));
    step();
    pair(2'b11, 32'h508, mk(0, 0, 0, 0, 0, 0, 0), 32'h50c, mk(0, 0, 0, 0, 0, 0, 0));
    step();
    pair(2'b11, 32'h510, mk(0, 0, 0, 0, 0, 0, 0), 32'h514, mk(0, 0, 0, 0, 0, 0, 0));
    step();
    bus.in_valid = 2'b00;
    step();
    check("t6_pre_ex0", bus.ex0_valid, 64'd1);
    check("t6_pre_ex1", bus.ex1_valid, 64'd1);
    check("t6_pre_full", bus.in_ready, 64'd0);
    s0 = m_stall;
    d0 = m_dual;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6_ex0_clr", bus.ex0_valid, 64'd0);
    check("t6_ex1_clr", bus.ex1_valid, 64'd0);
    check("t6_in_ready", bus.in_ready, 64'd1);
`ifdef ISSUE_PERF_CNT_EN
    check("t6_stall_kept", bus.stall_cnt, 64'(s0));
    check("t6_dual_kept", bus.dual_cnt, 64'(d0));
`endif
    idle();
    step();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 2);
      pair((r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11,
           $urandom(),
           mk($urandom_range(0, 3), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
              $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 7)),
           $urandom(),
           mk($urandom_range(0, 3), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
              $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 7)));
      for (int i = 0; i < NFWD; i++) begin
        bus.fwd_we[i]   = ($urandom_range(0, 3) == 0);
        bus.fwd_done[i] = ($urandom_range(0, 4) != 0);
        bus.fwd_addr[i*5 +: 5]   = 5'($urandom_range(0, 7));
        bus.fwd_data[i*DW +: DW] = $urandom();
      end
      bus.ex0_ready = ($urandom_range(0, 3) != 0);
      bus.ex1_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 15) == 0) rf_mem[$urandom_range(1, 7)] = $urandom();
      step();
    end

    // reset in the middle of traffic
    idle();
    bus.ex0_ready = 1'b0;
    pair(2'b11, 32'h600, mk(0, 0, 0, 0, 0, 0, 0), 32'h604, mk(0, 0, 0, 0, 0, 0, 0));
    step();
    step();
    rst_n = 1'b0;
    model_reset();
    #1;
    reset_checks("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
